// File: rtl/wr_ptr_full_if.sv
// Write-side bus of the async FIFO pointer block.
// The producer and the read-pointer synchroniser drive the master side.
// The write pointer/full logic sits on the slave side.
interface wr_ptr_full_if #(
  parameter int ADDR_WIDTH = 4
);

  logic                  wr_en;         // write request from producer
  logic [ADDR_WIDTH:0]   rd_gray_sync;  // read Gray pointer, already synced into wr_clk
  logic [ADDR_WIDTH-1:0] wr_addr;       // RAM write address
  logic [ADDR_WIDTH:0]   wr_gray;       // registered Gray write pointer, to read domain
  logic                  wr_push;       // RAM write-enable this cycle
  logic                  full;          // registered full flag
  logic                  almost_full;   // registered, free slots at or below threshold
  logic [ADDR_WIDTH:0]   wr_level;      // registered occupancy seen from wr_clk
  logic                  overflow;      // one-cycle pulse: write dropped while full

  modport master (
    output wr_en, rd_gray_sync,
    input  wr_addr, wr_gray, wr_push, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  wr_en, rd_gray_sync,
    output wr_addr, wr_gray, wr_push, full, almost_full, wr_level, overflow
  );

endinterface

// File: rtl/wr_ptr_full.sv
// Write-domain pointer and full-flag generator for an async FIFO.
// Keeps the binary/Gray write pointer and derives the RAM address.
// Compares the next pointer against the synced read Gray pointer to produce
// registered full, almost_full, level and overflow.
// Only the Gray pointers cross clock domains.
module wr_ptr_full #(
  parameter int ADDR_WIDTH    = 4,
  parameter int ALMOST_FULL_M = 2
) (
  input logic          wr_clk,
  input logic          wr_rst,
  wr_ptr_full_if.slave bus
);

  localparam int AW    = ADDR_WIDTH;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AFM_P   = PW'(ALMOST_FULL_M);

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] gray;
  logic [PW-1:0] level;
  logic          full;
  logic          almost_full;
  logic          overflow;
  logic          push;

  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] full_match;
  logic [PW-1:0] level_next;
  logic [PW-1:0] free_next;

  // A write is accepted only when the registered full flag allows it.
  // This keeps any combinational path from rd_gray_sync away from wr_push.
  assign push = bus.wr_en & ~full;

  // Next pointer, read-pointer decode and next occupancy.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it unassigned (no latch).
    bin_next   = '0;
    gray_next  = '0;
    rd_bin     = '0;
    full_match = '0;
    level_next = '0;
    free_next  = '0;

    bin_next  = wr_bin + PW'(push);
    gray_next = bin_next ^ (bin_next >> 1);

    // Gray to binary: each bit is the XOR of all Gray bits from the MSB down to it.
    for (int i = 0; i < PW; i++) begin
      rd_bin[i] = ^(bus.rd_gray_sync >> i);
    end

    // Full when the write pointer is exactly one lap (DEPTH) ahead of the read pointer.
    // In Gray code this means the top two bits are inverted and the rest are equal.
    full_match = {~bus.rd_gray_sync[AW:AW-1], bus.rd_gray_sync[AW-2:0]};

    // Occupancy wraps naturally modulo 2**PW; it never exceeds DEPTH.
    level_next = bin_next - rd_bin;
    free_next  = DEPTH_P - level_next;
  end

  // Pointer and status registers; reset discards all pointer state.
  always_ff @(posedge wr_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (wr_rst) begin
      wr_bin      <= '0;
      gray        <= '0;
      level       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_bin      <= bin_next;
      gray        <= gray_next;
      level       <= level_next;
      full        <= (gray_next == full_match);
      almost_full <= (free_next <= AFM_P);
      overflow    <= bus.wr_en & full;
    end
  end

  assign bus.wr_addr     = wr_bin[AW-1:0];
  assign bus.wr_gray     = gray;
  assign bus.wr_push     = push;
  assign bus.full        = full;
  assign bus.almost_full = almost_full;
  assign bus.wr_level    = level;
  assign bus.overflow    = overflow;

endmodule
